// File: rtl/button_event_pkg.sv
// Shared types for the button event classifier: event codes, FSM states and a small helper.
package button_event_pkg;

  typedef enum logic [1:0] {
    EVT_SHORT    = 2'd0,
    EVT_LONG     = 2'd1,
    EVT_REPEAT   = 2'd2,
    EVT_REL_LONG = 2'd3
  } evt_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick prescaler: one-cycle tick every CLK_FREQ/1000 clocks, restartable via clr.
module ms_tick_gen #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CycPerMs = CLK_FREQ / 1000;
  localparam int unsigned PreW     = (CycPerMs > 1) ? $clog2(CycPerMs) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(CycPerMs - 1);

  logic [PreW-1:0] pre_cnt_q, pre_cnt_d;

  assign tick = (pre_cnt_q == PreLast);

  always_comb begin
    pre_cnt_d = pre_cnt_q + 1'b1;
    if (clr || tick) begin
      pre_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/button_event.sv
// Classifies debounced button presses into SHORT/LONG/REPEAT/REL_LONG events and
// hands them out through a one-entry valid/ready slot with sticky overflow.
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_level,
  output logic evt_valid,
  output evt_e evt_code,
  input  logic evt_ready,
  output logic held,
  output logic overflow,
  input  logic overflow_clr
);

  localparam int unsigned MsMax = max_u(LONG_MS, REPEAT_MS);
  localparam int unsigned MsW   = $clog2(MsMax + 1);
  localparam logic [MsW-1:0] LongLast   = MsW'(LONG_MS - 1);
  localparam logic [MsW-1:0] RepeatLast = MsW'(REPEAT_MS - 1);

  logic           btn_q, primed_q;
  logic           rise, fall, tick;
  state_e         state_q, state_d;
  logic [MsW-1:0] ms_cnt_q, ms_cnt_d;
  logic           new_evt;
  evt_e           new_code;
  logic           evt_valid_q, evt_valid_d;
  evt_e           evt_code_q, evt_code_d;
  logic           overflow_q, overflow_d;
  logic           held_q;
  logic           drop;

  // A level held through reset must be seen low once before a press counts.
  assign rise = btn_level & ~btn_q & primed_q;
  assign fall = ~btn_level & btn_q;

  ms_tick_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_ms_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (rise),
    .tick    (tick)
  );

  always_comb begin
    state_d  = state_q;
    ms_cnt_d = ms_cnt_q;
    new_evt  = 1'b0;
    new_code = EVT_SHORT;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d  = PRESSED;
          ms_cnt_d = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
          new_evt = 1'b1;
          state_d = IDLE;
        end else if (tick) begin
          if (ms_cnt_q == LongLast) begin
            new_evt  = 1'b1;
            new_code = EVT_LONG;
            ms_cnt_d = '0;
            state_d  = LONG_HELD;
          end else begin
            ms_cnt_d = ms_cnt_q + 1'b1;
          end
        end
      end
      LONG_HELD: begin
        if (fall) begin
          new_evt  = 1'b1;
          new_code = EVT_REL_LONG;
          state_d  = IDLE;
        end else if (tick) begin
          if (ms_cnt_q == RepeatLast) begin
            new_evt  = 1'b1;
            new_code = EVT_REPEAT;
            ms_cnt_d = '0;
          end else begin
            ms_cnt_d = ms_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slot: a full slot being accepted this edge can take a new event without a bubble.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    drop        = 1'b0;
    if (new_evt) begin
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_code_d  = new_code;
      end else begin
        drop = 1'b1;
      end
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q       <= 1'b0;
      primed_q    <= 1'b0;
      state_q     <= IDLE;
      ms_cnt_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= EVT_SHORT;
      overflow_q  <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      btn_q       <= btn_level;
      primed_q    <= primed_q | ~btn_level;
      state_q     <= state_d;
      ms_cnt_q    <= ms_cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      overflow_q  <= overflow_d;
      held_q      <= (state_d != IDLE);
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign overflow  = overflow_q;
  assign held      = held_q;

endmodule
